// File: rtl/out_ctrl_pkg.sv
// Shared types and sizing for the systolic output controller.
// The state enum and beat sizing are used by the controller and its bench.
package out_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CAPTURE,
        LOAD,
        SEND,
        SHIFT,
        DONE
    } out_state_t;

    localparam int OUT_BEATS  = 8;
    localparam int OUT_BEAT_W = 3;

endpackage

// File: rtl/output_controller.sv
// Sequences capture, feeder load and the beat-by-beat drain of one 512-bit result tile.
// All outputs are decoded from registered state; the external shift counter is cross-checked.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   IDLE    | ready for a tile; buffer samples on the accepting edge
//   CAPTURE | one wait cycle so the buffer output settles
//   LOAD    | one-cycle parallel load of the feeder, beat index cleared
//   SEND    | beat offered downstream until accepted
//   SHIFT   | one-cycle feeder shift, beat index advances
//   DONE    | one-cycle completion pulse
module output_controller
    import out_ctrl_pkg::*;
#(
    parameter int NUM_BEATS = OUT_BEATS,
    parameter int BEAT_W    = OUT_BEAT_W
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              flush_i,
    input  logic              tile_valid_i,
    output logic              tile_ready_o,
    output logic              load_out_o,
    output logic              shift_o,
    output logic              dest_valid_o,
    input  logic              tx_two_done_i,
    input  logic              sh_count_done_i,
    output logic [BEAT_W-1:0] beat_idx_o,
    output logic              busy_o,
    output logic              tile_done_o,
    output logic              seq_error_o
);

    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(NUM_BEATS - 1);
    localparam logic [BEAT_W-1:0] LAST_SHIFT = BEAT_W'(NUM_BEATS - 2);

    out_state_t        state_q, state_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic              cnt_seen_q, cnt_seen_d;
    logic              seq_error_q, seq_error_d;
    logic              in_window;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            cnt_seen_q  <= 1'b0;
            seq_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            cnt_seen_q  <= cnt_seen_d;
            seq_error_q <= seq_error_d;
        end
    end

    // The counter's terminal pulse is legal from the last SHIFT through DONE.
    always_comb begin
        in_window = ((state_q == SHIFT) && (beat_q == LAST_SHIFT)) ||
                    ((state_q == SEND)  && (beat_q == LAST_BEAT))  ||
                    (state_q == DONE);
    end

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        cnt_seen_d  = cnt_seen_q;
        seq_error_d = seq_error_q;

        unique case (state_q)
            IDLE:    if (tile_valid_i) state_d = CAPTURE;
            CAPTURE: state_d = LOAD;
            LOAD: begin
                state_d    = SEND;
                beat_d     = '0;
                cnt_seen_d = 1'b0;
            end
            SEND:    if (tx_two_done_i) state_d = (beat_q == LAST_BEAT) ? DONE : SHIFT;
            SHIFT: begin
                state_d = SEND;
                beat_d  = beat_q + BEAT_W'(1);
            end
            DONE: begin
                state_d = IDLE;
                beat_d  = '0;
            end
            default: state_d = IDLE;
        endcase

        if (sh_count_done_i) begin
            if (in_window) cnt_seen_d  = 1'b1;
            else           seq_error_d = 1'b1;
        end
        if (tx_two_done_i && (state_q != SEND)) seq_error_d = 1'b1;
        if ((state_q == DONE) && !cnt_seen_q)   seq_error_d = 1'b1;

        // Abort wins over every transition but keeps the sticky error.
        if (flush_i) begin
            state_d    = IDLE;
            beat_d     = '0;
            cnt_seen_d = 1'b0;
        end
    end

    assign tile_ready_o = (state_q == IDLE);
    assign load_out_o   = (state_q == LOAD);
    assign shift_o      = (state_q == SHIFT);
    assign dest_valid_o = (state_q == SEND);
    assign tile_done_o  = (state_q == DONE);
    assign busy_o       = (state_q != IDLE);
    assign beat_idx_o   = beat_q;
    assign seq_error_o  = seq_error_q;

endmodule

// File: tb/tb_output_controller.sv
// Bench for output_controller: a fixed timing table, then scripted/random tiles
// checked cycle by cycle against a per-tile expected-output script.
module tb_output_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       tile_valid = 1'b0;
    logic       tx = 1'b0;
    logic       scd = 1'b0;
    logic       tile_ready, load_out, shift, dest_valid, busy, tile_done, seq_error;
    logic [2:0] beat_idx;

    always #5 clk = ~clk;

    output_controller dut (
        .clk_i           (clk),
        .reset_ni        (rst_n),
        .flush_i         (flush),
        .tile_valid_i    (tile_valid),
        .tile_ready_o    (tile_ready),
        .load_out_o      (load_out),
        .shift_o         (shift),
        .dest_valid_o    (dest_valid),
        .tx_two_done_i   (tx),
        .sh_count_done_i (scd),
        .beat_idx_o      (beat_idx),
        .busy_o          (busy),
        .tile_done_o     (tile_done),
        .seq_error_o     (seq_error)
    );

    // One expected cycle of a tile: outputs plus the handshake the bench will drive.
    typedef struct {
        bit rdy, ld, sh, dv, bsy, dn;
        int beat;
        bit tx, win, scd;
    } slot_t;

    typedef struct {
        bit         tv, tx, scd;
        logic [9:0] exp;
    } vec_t;

    slot_t q[$];
    vec_t  tbl[20];
    bit    exp_err = 1'b0;
    bit    seen = 1'b0;
    int    errors = 0;
    int    checks = 0;
    int    stall_max = 0;
    int    tiles_done = 0;

    function automatic slot_t mk(bit rdy, bit ld, bit sh, bit dv, bit bsy, bit dn,
                                 int beat, bit t, bit win, bit s);
        slot_t r;
        r.rdy = rdy; r.ld = ld; r.sh = sh; r.dv = dv; r.bsy = bsy; r.dn = dn;
        r.beat = beat; r.tx = t; r.win = win; r.scd = s;
        return r;
    endfunction

    function automatic logic [9:0] dut_vec();
        return {tile_ready, load_out, shift, dest_valid, busy, tile_done, seq_error, beat_idx};
    endfunction

    function automatic void chk(string nm, logic [9:0] act, logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b required %b (rdy ld sh dv bsy dn err beat[3])", nm, act, exp);
        end
    endfunction

    // Script of a whole tile: capture, load, 8 beats with random stalls, 7 shifts, done.
    task automatic build_tile();
        int st;
        q.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        q.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        for (int b = 0; b < 8; b++) begin
            st = (stall_max > 0) ? $urandom_range(0, stall_max) : 0;
            for (int s = 0; s <= st; s++)
                q.push_back(mk(0, 0, 0, 1, 1, 0, b, s == st, b == 7, (b == 7) && (s == 0)));
            if (b < 7) q.push_back(mk(0, 0, 1, 0, 1, 0, b, 0, b == 6, 0));
        end
        q.push_back(mk(0, 0, 0, 0, 1, 1, 7, 0, 1, 0));
    endtask

    task automatic step(input bit tv, input bit fl, input bit xscd, input bit xtx, input string nm);
        slot_t cur;
        cur = (q.size() > 0) ? q[0] : mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk(nm, dut_vec(), {cur.rdy, cur.ld, cur.sh, cur.dv, cur.bsy, cur.dn, exp_err, 3'(cur.beat)});
        tile_valid = tv;
        flush      = fl;
        tx         = cur.tx | xtx;
        scd        = cur.scd | xscd;
        if (tx && !cur.dv)      exp_err = 1'b1;
        if (scd && !cur.win)    exp_err = 1'b1;
        if (cur.dn && !seen)    exp_err = 1'b1;
        if (cur.ld)             seen = 1'b0;
        if (scd && cur.win)     seen = 1'b1;
        if (fl) begin
            q.delete();
            seen = 1'b0;
        end else if (q.size() > 0) begin
            if (cur.dn) tiles_done++;
            void'(q.pop_front());
        end else if (tv) begin
            build_tile();
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; tile_valid = 1'b0; flush = 1'b0; tx = 1'b0; scd = 1'b0;
        q.delete(); exp_err = 1'b0; seen = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic drain(input string nm);
        for (int i = 0; i < 200 && q.size() > 0; i++) step(0, 0, 0, 0, nm);
        chk({nm, "_drained"}, 10'(q.size() == 0), 10'd1);
    endtask

    initial begin
        int  c, t0;
        bit  found;

        // Nominal single-tile timing, derived directly from the cycle numbers.
        for (c = 0; c < 20; c++) begin
            bit ld, sh, dv, dn, bsy, rdy;
            int b;
            rdy = (c == 0) || (c == 19);
            ld  = (c == 2);
            dv  = (c >= 3) && (c <= 17) && (c % 2 == 1);
            sh  = (c >= 4) && (c <= 16) && (c % 2 == 0);
            dn  = (c == 18);
            bsy = (c >= 1) && (c <= 18);
            b   = dv ? (c - 3) / 2 : sh ? (c - 4) / 2 : dn ? 7 : 0;
            tbl[c].tv  = (c == 0);
            tbl[c].tx  = dv;
            tbl[c].scd = (c == 17);
            tbl[c].exp = {rdy, ld, sh, dv, bsy, dn, 1'b0, 3'(b)};
        end

        do_reset();
        chk("reset_state", dut_vec(), 10'b1000100000 & 10'b1000000000);
        for (c = 0; c < 20; c++) begin
            chk($sformatf("table_c%0d", c), dut_vec(), tbl[c].exp);
            tile_valid = tbl[c].tv;
            tx         = tbl[c].tx;
            scd        = tbl[c].scd;
            @(posedge clk); #1;
        end
        tile_valid = 1'b0; tx = 1'b0; scd = 1'b0;

        // Back-to-back tiles with tile_valid held high and backpressure.
        stall_max = 3;
        t0 = tiles_done;
        for (int i = 0; i < 60; i++) step(1, 0, 0, 0, "b2b");
        drain("b2b");
        chk("b2b_tiles", 10'(tiles_done - t0 >= 2), 10'd1);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 2) != 0, (q.size() > 0) && ($urandom_range(0, 40) == 0), 0, 0, "rand");
        drain("rand");

        // Flush in SEND at beat 4, then a clean tile.
        stall_max = 0;
        step(1, 0, 0, 0, "flush_start");
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (q.size() > 0 && q[0].dv && q[0].beat == 4) found = 1;
            else step(0, 0, 0, 0, "flush_run");
        end
        chk("flush_reach", 10'(found), 10'd1);
        t0 = tiles_done;
        step(0, 1, 0, 0, "flush_edge");
        step(1, 0, 0, 0, "flush_idle");
        drain("flush_next");
        chk("flush_tiles", 10'(tiles_done - t0), 10'd1);

        // Early counter pulse during beat 2 gives a sticky error.
        step(1, 0, 0, 0, "scd_start");
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (q.size() > 0 && q[0].dv && q[0].beat == 2) found = 1;
            else step(0, 0, 0, 0, "scd_run");
        end
        chk("scd_reach", 10'(found), 10'd1);
        step(0, 0, 1, 0, "scd_early");
        drain("scd_tile");
        step(1, 0, 0, 0, "scd_next");
        drain("scd_sticky");
        chk("scd_err_held", 10'(seq_error), 10'd1);

        // Stray handshake in IDLE.
        do_reset();
        step(0, 0, 0, 1, "tx_idle");
        step(0, 0, 0, 0, "tx_idle_err");

        // Asynchronous reset in the middle of a SHIFT cycle.
        do_reset();
        step(1, 0, 0, 0, "arst_start");
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (q.size() > 0 && q[0].sh && q[0].beat == 3) found = 1;
            else step(0, 0, 0, 0, "arst_run");
        end
        chk("arst_reach", 10'(found), 10'd1);
        tx = 1'b0; scd = 1'b0;
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        q.delete(); seen = 1'b0; exp_err = 1'b0;
        #1 chk("arst_release", dut_vec(), 10'b1000000000);
        @(posedge clk); #1;
        t0 = tiles_done;
        step(1, 0, 0, 0, "arst_next");
        drain("arst_next");
        chk("arst_tiles", 10'(tiles_done - t0), 10'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

endmodule
